// File: rtl/ly_hit_stretcher.sv
// ly_hit_stretcher: per-channel pulse stretcher for one anode layer.
// Each single-cycle one-shot pulse on lyr[i] is widened to drift_delay clocks
// (0 treated as 1) so that hits from different layers overlap in time for the
// pattern finder. A retrigger reloads the window from the latest pulse.
// Also reports the per-cycle count of accepted pulses (nhit) and layer activity.
// Optional build macro: LY_HOT_MASK_EN adds a hot_mask input that blocks
// new loads on noisy channels without cutting stretches already running.
module ly_hit_stretcher #(
  parameter int CH = 96,
  parameter int WW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] lyr,
  input  logic          trig_stop,
  input  logic [WW-1:0] drift_delay,
`ifdef LY_HOT_MASK_EN
  input  logic [CH-1:0] hot_mask,
`endif
  output logic [CH-1:0] lys,
  output logic [6:0]    nhit,
  output logic          ly_busy
);

  localparam logic [WW-1:0] ONE = WW'(1);

  // Stretch length applied to channels loading this cycle; 0 means 1.
  logic [WW-1:0] len;
  assign len = (drift_delay == '0) ? ONE : drift_delay;

  // Accepted new pulses: trig_stop drops them outright (no deferral).
  logic [CH-1:0] load;
`ifdef LY_HOT_MASK_EN
  assign load = lyr & ~{CH{trig_stop}} & ~hot_mask;
`else
  assign load = lyr & ~{CH{trig_stop}};
`endif

  // Next-cycle activity of every channel, used for both lys and ly_busy.
  logic [CH-1:0] active_d;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [WW-1:0] cnt_q;
      logic [WW-1:0] cnt_d;

      // Down-counter next state: reload on pulse, otherwise count down to zero.
      always_comb begin
        cnt_d = cnt_q;
        if (load[gi]) begin
          cnt_d = len;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - ONE;
        end
      end

      // Counter register; reset clears any stretch and discards a coincident pulse.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign active_d[gi] = (cnt_d != '0);
    end
  endgenerate

  // Popcount of accepted loads; registered so it lines up with the lys rising edge.
  logic [6:0] nhit_d;
  always_comb begin
    nhit_d = '0;
    for (int i = 0; i < CH; i++) begin
      nhit_d = nhit_d + 7'(load[i]);
    end
  end

  // Output registers: lys mirrors counter activity, ly_busy is its OR.
  logic [CH-1:0] lys_q;
  logic [6:0]    nhit_q;
  logic          ly_busy_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      lys_q     <= '0;
      nhit_q    <= '0;
      ly_busy_q <= 1'b0;
    end else begin
      lys_q     <= active_d;
      nhit_q    <= nhit_d;
      ly_busy_q <= |active_d;
    end
  end

  assign lys     = lys_q;
  assign nhit    = nhit_q;
  assign ly_busy = ly_busy_q;

endmodule

// File: tb/tb_ly_hit_stretcher.sv
// Directed testbench for ly_hit_stretcher (CH=96, WW=4).
module tb_ly_hit_stretcher;

  localparam int CH = 96;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] lyr;
  logic          trig_stop;
  logic [WW-1:0] drift_delay;
`ifdef LY_HOT_MASK_EN
  logic [CH-1:0] hot_mask;
`endif
  logic [CH-1:0] lys;
  logic [6:0]    nhit;
  logic          ly_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ly_hit_stretcher #(.CH(CH), .WW(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .lyr         (lyr),
    .trig_stop   (trig_stop),
    .drift_delay (drift_delay),
`ifdef LY_HOT_MASK_EN
    .hot_mask    (hot_mask),
`endif
    .lys         (lys),
    .nhit        (nhit),
    .ly_busy     (ly_busy)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check all three outputs for one cycle.
  task automatic chk_all(input string tag, input logic [CH-1:0] exp_lys, input int exp_nhit);
    chk({tag, " lys"}, lys, exp_lys);
    chk({tag, " nhit"}, CH'(nhit), CH'(exp_nhit));
    chk({tag, " busy"}, CH'(ly_busy), CH'(exp_lys != '0));
  endtask

  // Single pulse on channel ch with stretch length len (drift_delay dd).
  task automatic pulse_run(input string tag, input int ch, input logic [WW-1:0] dd, input int len);
    logic [CH-1:0] b;
    b = '0;
    b[ch] = 1'b1;
    drift_delay = dd;
    lyr = b;
    tick();
    lyr = '0;
    for (int k = 1; k <= len + 1; k++) begin
      chk_all($sformatf("%s c%0d", tag, k), (k <= len) ? b : '0, (k == 1) ? 1 : 0);
      $display("%s cycle %0d: lys=%h nhit=%0d busy=%0b", tag, k, lys, nhit, ly_busy);
      if (k <= len) tick();
    end
  endtask

  initial begin
    logic [CH-1:0] b10, b20, b30, b40, b41, ones;
    b10 = '0; b10[10] = 1'b1;
    b20 = '0; b20[20] = 1'b1;
    b30 = '0; b30[30] = 1'b1;
    b40 = '0; b40[40] = 1'b1;
    b41 = '0; b41[41] = 1'b1;
    ones = '1;

    rst = 1'b1; lyr = '0; trig_stop = 1'b0; drift_delay = 4'd3;
`ifdef LY_HOT_MASK_EN
    hot_mask = '0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk_all("reset", '0, 0);
    $display("reset: lys=%h nhit=%0d busy=%0b", lys, nhit, ly_busy);

    // Basic stretch and the drift_delay boundaries.
    pulse_run("dd3_ch5", 5, 4'd3, 3);
    pulse_run("dd0_ch0", 0, 4'd0, 1);
    pulse_run("dd15_ch95", 95, 4'd15, 15);

    // Retrigger: pulses at cycles 0 and 2, dd=4 -> high cycles 1..6.
    drift_delay = 4'd4;
    lyr = b10; tick();
    chk_all("retrig c1", b10, 1); lyr = '0; tick();
    chk_all("retrig c2", b10, 0); lyr = b10; tick();
    chk_all("retrig c3", b10, 1); lyr = '0;
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk_all($sformatf("retrig c%0d", k), (k <= 6) ? b10 : '0, 0);
    end
    $display("retrigger: done, lys=%h", lys);

    // trig_stop: later pulses (ch20 retrigger, ch30) dropped.
    drift_delay = 4'd5;
    lyr = b20; tick();
    chk_all("tstop c1", b20, 1); lyr = '0; trig_stop = 1'b1; tick();
    chk_all("tstop c2", b20, 0); tick();
    chk_all("tstop c3", b20, 0); lyr = b20 | b30; tick();
    chk_all("tstop c4", b20, 0); lyr = '0; tick();
    chk_all("tstop c5", b20, 0); tick();
    chk_all("tstop c6", '0, 0);
    trig_stop = 1'b0;
    $display("trig_stop: done, lys=%h", lys);

    // drift_delay change mid-stretch: ch40 keeps its count, ch41 uses new value.
    drift_delay = 4'd6;
    lyr = b40; tick();
    chk_all("ddchg c1", b40, 1);
    drift_delay = 4'd2; lyr = b41; tick();
    lyr = '0;
    for (int k = 2; k <= 7; k++) begin
      chk_all($sformatf("ddchg c%0d", k), ((k <= 6) ? b40 : '0) | ((k <= 3) ? b41 : '0), (k == 2) ? 1 : 0);
      if (k < 7) tick();
    end
    $display("drift change: done, lys=%h", lys);

    // All channels at once, then reset mid-stretch with a coincident pulse.
    drift_delay = 4'd2;
    lyr = ones; tick();
    chk_all("all c1", ones, 96); lyr = '0; tick();
    chk_all("all c2", ones, 0);
    rst = 1'b1; lyr = ones; tick();
    chk_all("all rst", '0, 0);
    rst = 1'b0; lyr = '0; tick();
    chk_all("all post", '0, 0);
    $display("all channels + reset: lys=%h nhit=%0d busy=%0b", lys, nhit, ly_busy);

`ifdef LY_HOT_MASK_EN
    begin
      logic [CH-1:0] b7, b8;
      b7 = '0; b7[7] = 1'b1;
      b8 = '0; b8[8] = 1'b1;
      drift_delay = 4'd2;
      hot_mask = b7;
      lyr = b7 | b8; tick();
      chk_all("mask c1", b8, 1);
      // Mask asserted on an active channel must not cut its stretch.
      hot_mask = b7 | b8; lyr = '0; tick();
      chk_all("mask c2", b8, 0); tick();
      chk_all("mask c3", '0, 0);
      hot_mask = '0;
      $display("hot mask: done, lys=%h", lys);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ly_hit_stretcher.md
Name: ly_hit_stretcher

Overview:
- Per-channel pulse stretcher for one anode layer.
- Sits directly downstream of the layer one-shot stage and consumes its single-cycle wire-group pulses.
- Widens each pulse to a programmable number of bunch crossings (drift window) so the downstream pattern finder sees coincident hits across layers.
- Also reports per-cycle new-hit count and layer-busy status.

Parameters:
- CH, 96, number of wire-group channels in the layer
- WW, 4, width of the stretch-length (drift delay) control

Ports:
- clk  in  1  system clock (LHC bunch-crossing clock)
- rst  in  1  synchronous reset, active-high
- lyr  in  CH  one-shot pulses from the layer one-shot stage, one bit per channel
- trig_stop  in  1  when high, new pulses are not accepted; active stretches continue to expire
- drift_delay  in  WW  stretch length in clocks; 0 is treated as 1
- lys  out  CH  stretched hits to the pattern finder
- nhit  out  7  number of channels loaded (accepted new pulse) in the previous cycle, 0..96
- ly_busy  out  1  high when any lys bit is high

Behaviour:
- Per channel: a WW-bit down-counter cnt[i]. lys[i] is registered and equals (cnt[i] != 0).
- Effective length: L = (drift_delay == 0) ? 1 : drift_delay. drift_delay is sampled at load time only.
- Load condition: load[i] = lyr[i] & ~trig_stop.
- Cycle rule:
  - if rst: cnt[i] <= 0;
  - else if load[i]: cnt[i] <= L (retrigger reloads; the window extends from the latest pulse);
  - else if cnt[i] != 0: cnt[i] <= cnt[i] - 1.
- Latency: a pulse on lyr[i] in cycle n gives lys[i]=1 in cycles n+1 .. n+L, and 0 in cycle n+L+1 unless retriggered.
- Counter never wraps: decrement occurs only when non-zero.
- trig_stop:
  - Gates loads only, so the layer drains within at most 15 clocks.
  - A pulse coincident with trig_stop=1 is dropped permanently; it is not deferred.
- drift_delay change mid-stretch: channels already counting keep their remaining count. New loads use the new value.
- nhit: registered popcount of load[CH-1:0]; same timing as the lys rising edge.
- ly_busy: registered OR of the next-state (cnt != 0) values, so it is cycle-aligned with lys.
- Reset values: lys=0, nhit=0, ly_busy=0, all counters 0.
- Reset asserted mid-stretch: all outputs are 0 on the cycle after rst is sampled high. A pulse present in the same cycle as rst is discarded.
- Channels are fully independent. Simultaneous pulses on all 96 channels give nhit=96.

Optional Feature:
- Macro: LY_HOT_MASK_EN.
- When defined:
  - Adds input port hot_mask [CH-1:0].
  - Load condition becomes lyr[i] & ~trig_stop & ~hot_mask[i].
  - Masked channels are excluded from nhit and never raise lys.
  - Asserting the mask on an active channel does not cut its current stretch.
- When undefined: no hot_mask port; all channels can load.

Test Plan:
- Reset, then lyr[5]=1 for 1 clk with drift_delay=3 -> lys[5]=1 for exactly 3 clks starting next cycle; nhit=1 for one cycle; ly_busy matches lys[5].
- drift_delay=0, pulse on ch 0 -> lys[0] high for exactly 1 clk. drift_delay=15 -> high for 15 clks.
- Retrigger: drift_delay=4, pulses on ch 10 at cycles 0 and 2 -> lys[10] high cycles 1..6 (6 clks); nhit=1 at cycles 1 and 3.
- trig_stop: pulse ch 20 at cycle 0 (drift_delay=5), trig_stop=1 from cycle 1, second pulse ch 20 at cycle 3 -> lys[20] high cycles 1..5 only; pulse on ch 30 at cycle 3 ignored.
- All 96 channels pulsed together, drift_delay=2 -> lys=all ones for 2 clks; nhit=96 for 1 clk; rst asserted during second stretch cycle -> all outputs 0 next cycle.
- With LY_HOT_MASK_EN, hot_mask[7]=1, pulse ch 7 and ch 8 -> only lys[8] asserted; nhit=1.
